odd_even: RTL and testbench

ODD_EVEN -- requirements
Module: odd_even

---
 rtl/odd_even_pkg.sv | 14 +
 rtl/odd_even_popcnt.sv | 19 +
 rtl/odd_even.sv | 86 ++++++++
 tb/tb_odd_even.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/odd_even_pkg.sv
// Shared defaults and types for the odd_even parity checker.
// The optional counters are enabled by defining ODD_EVEN_CNT_EN.
package odd_even_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int ONES_W_DEF = $clog2(DATA_W_DEF + 1);

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_e;

endpackage

// File: rtl/odd_even_popcnt.sv
// Combinational population count of a DATA_W-bit word.
module odd_even_popcnt
  import odd_even_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ONES_W = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [ONES_W-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      o_count = o_count + ONES_W'(i_data[i]);
    end
  end

endmodule

// File: rtl/odd_even.sv
// Registered parity / population count of a qualified data word.
// Define ODD_EVEN_CNT_EN to add saturating odd/even sample counters.
module odd_even
  import odd_even_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int ONES_W = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  input  logic              d_valid,
  output logic              out,
  output logic              out_valid,
  output logic [ONES_W-1:0] ones
`ifdef ODD_EVEN_CNT_EN
  ,
  output logic [CNT_W-1:0]  odd_cnt,
  output logic [CNT_W-1:0]  even_cnt
`endif
);

  if (DATA_W < 1 || CNT_W < 1) begin : g_bad_param
    $error("odd_even: DATA_W and CNT_W must be at least 1");
  end

  logic [ONES_W-1:0] w_ones;
  parity_e           w_parity;

  logic              r_out;
  logic              r_out_valid;
  logic [ONES_W-1:0] r_ones;

  odd_even_popcnt #(
    .DATA_W (DATA_W),
    .ONES_W (ONES_W)
  ) u_popcnt (
    .i_data  (d),
    .o_count (w_ones)
  );

  // The LSB of the population count is the XOR reduction of d.
  assign w_parity = parity_e'(w_ones[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_ones      <= '0;
    end else begin
      r_out_valid <= d_valid;
      if (d_valid) begin
        r_out  <= (w_parity == ODD);
        r_ones <= w_ones;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign ones      = r_ones;

`ifdef ODD_EVEN_CNT_EN
  logic [CNT_W-1:0] r_odd_cnt;
  logic [CNT_W-1:0] r_even_cnt;

  // Each counter sticks at all-ones; the other keeps counting on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_odd_cnt  <= '0;
      r_even_cnt <= '0;
    end else if (d_valid) begin
      if (w_parity == ODD) begin
        if (r_odd_cnt != '1) r_odd_cnt <= r_odd_cnt + CNT_W'(1);
      end else begin
        if (r_even_cnt != '1) r_even_cnt <= r_even_cnt + CNT_W'(1);
      end
    end
  end

  assign odd_cnt  = r_odd_cnt;
  assign even_cnt = r_even_cnt;
`endif

endmodule

// File: tb/tb_odd_even.sv
// Self-checking bench for odd_even; counter checks compile in with ODD_EVEN_CNT_EN.
module tb_odd_even;
  import odd_even_pkg::*;

  localparam int CNT_MAX = (1 << CNT_W_DEF) - 1;
  localparam int SAT_MAX = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1;
  logic [DATA_W_DEF-1:0] d = '0;
  logic                  d_valid = 1'b0;
  logic                  out;
  logic                  out_valid;
  logic [ONES_W_DEF-1:0] ones;
`ifdef ODD_EVEN_CNT_EN
  logic [CNT_W_DEF-1:0]  odd_cnt;
  logic [CNT_W_DEF-1:0]  even_cnt;
  logic                  s_rst = 1'b1;
  logic [DATA_W_DEF-1:0] s_d = '0;
  logic                  s_valid = 1'b0;
  logic                  s_out;
  logic                  s_out_valid;
  logic [ONES_W_DEF-1:0] s_ones;
  logic [1:0]            s_odd_cnt;
  logic [1:0]            s_even_cnt;
`endif

  odd_even dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .d_valid   (d_valid),
    .out       (out),
    .out_valid (out_valid),
    .ones      (ones)
`ifdef ODD_EVEN_CNT_EN
    ,
    .odd_cnt   (odd_cnt),
    .even_cnt  (even_cnt)
`endif
  );

`ifdef ODD_EVEN_CNT_EN
  odd_even #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (s_rst),
    .d         (s_d),
    .d_valid   (s_valid),
    .out       (s_out),
    .out_valid (s_out_valid),
    .ones      (s_ones),
    .odd_cnt   (s_odd_cnt),
    .even_cnt  (s_even_cnt)
  );
`endif

  // reference model: values the outputs should show after the last edge
  logic                  m_out = 1'b0;
  logic                  m_valid = 1'b0;
  logic [ONES_W_DEF-1:0] m_ones = '0;
  int                    m_odd = 0;
  int                    m_even = 0;

  int n_cmp = 0;
  int n_err = 0;

  // driver: apply inputs, take one edge, advance model, land 1ns past the edge
  task automatic drive(input logic r, input logic v, input logic [DATA_W_DEF-1:0] dd);
    int pc;
    rst = r; d_valid = v; d = dd;
    @(posedge clk);
    #1;
    if (r) begin
      m_out = 1'b0; m_valid = 1'b0; m_ones = '0; m_odd = 0; m_even = 0;
    end else begin
      m_valid = v;
      if (v) begin
        pc = $countones(dd);
        m_ones = ONES_W_DEF'(pc);
        m_out  = (pc % 2) == 1;
        if (m_out) m_odd  = (m_odd  < CNT_MAX) ? m_odd + 1  : CNT_MAX;
        else       m_even = (m_even < CNT_MAX) ? m_even + 1 : CNT_MAX;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'(i), DATA_W_DEF'($urandom));
      n_cmp++;
      if (out !== 1'b0 || out_valid !== 1'b0 || ones !== '0) begin
        n_err++;
        $display("FAIL reset: out=%b valid=%b ones=%0d, need 0/0/0", out, out_valid, ones);
      end
`ifdef ODD_EVEN_CNT_EN
      n_cmp++;
      if (odd_cnt !== '0 || even_cnt !== '0) begin
        n_err++;
        $display("FAIL reset_cnt: odd=%0d even=%0d, need 0/0", odd_cnt, even_cnt);
      end
`endif
    end
  endtask

  task automatic test_directed();
    logic [7:0] seq_d    [3] = '{8'h01, 8'h0C, 8'h54};
    logic       seq_out  [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] seq_ones [3] = '{4'd1, 4'd2, 4'd3};
    // all-zero word is even
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    n_cmp++;
    if (out !== 1'b0 || ones !== 4'd0 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL zero_word: out=%b ones=%0d valid=%b, need 0/0/1", out, ones, out_valid);
    end
`ifdef ODD_EVEN_CNT_EN
    n_cmp++;
    if (even_cnt !== 16'd1 || odd_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL zero_word_cnt: odd=%0d even=%0d, need 0/1", odd_cnt, even_cnt);
    end
`endif
    // three consecutive valid words
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, seq_d[i]);
      n_cmp++;
      if (out !== seq_out[i] || ones !== seq_ones[i] || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL seq3[%0d]: out=%b ones=%0d valid=%b, need %b/%0d/1",
                 i, out, ones, out_valid, seq_out[i], seq_ones[i]);
      end
    end
`ifdef ODD_EVEN_CNT_EN
    n_cmp++;
    if (odd_cnt !== 16'd2 || even_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL seq3_cnt: odd=%0d even=%0d, need 2/1", odd_cnt, even_cnt);
    end
`endif
    // all-ones then hold with d_valid low
    drive(1'b0, 1'b1, 8'hFF);
    n_cmp++;
    if (out !== 1'b0 || ones !== 4'd8 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ff_word: out=%b ones=%0d valid=%b, need 0/8/1", out, ones, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h01);
      n_cmp++;
      if (out !== 1'b0 || ones !== 4'd8 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: out=%b ones=%0d valid=%b, need 0/8/0", i, out, ones, out_valid);
      end
    end
  endtask

  task automatic test_reset_collision();
    logic [7:0] nd;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'($urandom));
    drive(1'b1, 1'b1, 8'h07);
    n_cmp++;
    if (out !== 1'b0 || ones !== 4'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_collide: out=%b ones=%0d valid=%b, need 0/0/0", out, ones, out_valid);
    end
`ifdef ODD_EVEN_CNT_EN
    n_cmp++;
    if (odd_cnt !== '0 || even_cnt !== '0) begin
      n_err++;
      $display("FAIL rst_collide_cnt: odd=%0d even=%0d, need 0/0", odd_cnt, even_cnt);
    end
`endif
    nd = 8'($urandom);
    drive(1'b0, 1'b1, nd);
    n_cmp++;
    if (out !== m_out || ones !== m_ones || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL after_rst d=%h: out=%b ones=%0d valid=%b, need %b/%0d/1",
               nd, out, ones, out_valid, m_out, m_ones);
    end
  endtask

  task automatic test_random(input int n, input bit all_valid);
    logic       r, v;
    logic [7:0] dd;
    for (int i = 0; i < n; i++) begin
      r  = all_valid ? 1'b0 : ($urandom_range(0, 29) == 0);
      v  = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
      dd = 8'($urandom);
      drive(r, v, dd);
      n_cmp++;
      if (out !== m_out || ones !== m_ones || out_valid !== m_valid) begin
        n_err++;
        $display("FAIL random[%0d] d=%h v=%b r=%b: out=%b ones=%0d valid=%b, need %b/%0d/%b",
                 i, dd, v, r, out, ones, out_valid, m_out, m_ones, m_valid);
      end
`ifdef ODD_EVEN_CNT_EN
      n_cmp++;
      if (odd_cnt !== 16'(m_odd) || even_cnt !== 16'(m_even)) begin
        n_err++;
        $display("FAIL random_cnt[%0d]: odd=%0d even=%0d, need %0d/%0d",
                 i, odd_cnt, even_cnt, m_odd, m_even);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    test_random(60, 1'b1);
  endtask

`ifdef ODD_EVEN_CNT_EN
  task automatic test_saturation();
    logic [7:0] odd_words [5] = '{8'h01, 8'h07, 8'h80, 8'hFE, 8'h2A};
    int exp_odd;
    s_rst = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    s_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_d = odd_words[i];
      @(posedge clk); #1;
      exp_odd = (i + 1 < SAT_MAX) ? i + 1 : SAT_MAX;
      n_cmp++;
      if (s_odd_cnt !== 2'(exp_odd) || s_even_cnt !== 2'd0) begin
        n_err++;
        $display("FAIL sat_odd[%0d]: odd=%0d even=%0d, need %0d/0", i, s_odd_cnt, s_even_cnt, exp_odd);
      end
    end
    s_d = 8'h03;
    @(posedge clk); #1;
    s_valid = 1'b0;
    n_cmp++;
    if (s_odd_cnt !== 2'd3 || s_even_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL sat_other: odd=%0d even=%0d, need 3/1", s_odd_cnt, s_even_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_reset_collision();
    test_random(300, 1'b0);
    test_back_to_back();
`ifdef ODD_EVEN_CNT_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
